// File: rtl/mac_qsfp_pktgen.sv
// Fixed-length Ethernet test-frame source on the MAC TX AXI4-Stream; first beat appears 3 edges after enable rises.
// tvalid/tdata come from registered state only; a stalled beat holds until tready, so no ready->valid path exists.
module mac_qsfp_pktgen #(
  parameter int          FRAME_BYTES = 60,
  parameter int          NUM_FRAMES  = 16,
  parameter int          IFG_CYCLES  = 4,
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0A35_0001_0203,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
  input  logic        gen_clk,
  input  logic        gen_resetn,
  input  logic        pktgen_enable,
  output logic [63:0] tx_axis_tdata,
  output logic [7:0]  tx_axis_tkeep,
  output logic        tx_axis_tvalid,
  input  logic        tx_axis_tready,
  output logic        tx_axis_tlast,
  output logic        tx_axis_tuser,
  output logic        busy,
  output logic        done,
  output logic [31:0] frames_sent,
  output logic [47:0] bytes_sent
);

  localparam int BEATS = (FRAME_BYTES + 7) / 8;
  localparam logic [7:0] LAST_KEEP = ((FRAME_BYTES % 8) == 0) ? 8'hFF
                                   : 8'((1 << (FRAME_BYTES % 8)) - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, en_s_q;
  logic [15:0] beat_q, beat_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] ep_q, ep_d;
  logic [31:0] gap_q, gap_d;
  logic [31:0] frames_q, frames_d;
  logic [47:0] bytes_q, bytes_d;
  logic        done_q, done_d;

  logic        valid;
  logic        hs;
  logic        last_beat;
  logic [7:0]  keep;
  logic [63:0] data;
  logic [3:0]  keep_cnt;

  function automatic logic [7:0] byte_at(input int n, input logic [31:0] seq);
    if (n < 6)                 return DST_MAC[8*(5-n) +: 8];
    else if (n < 12)           return SRC_MAC[8*(11-n) +: 8];
    else if (n < 14)           return ETHERTYPE[8*(13-n) +: 8];
    else if (n < 18)           return seq[8*(17-n) +: 8];
    else if (n < FRAME_BYTES)  return 8'(n - 18);
    else                       return 8'h00;
  endfunction

  // Beat content is derived from the beat index and seq, both of which only move on a handshake.
  always_comb begin
    last_beat = (beat_q == 16'(BEATS - 1));
    keep      = last_beat ? LAST_KEEP : 8'hFF;
    data      = '0;
    keep_cnt  = '0;
    for (int i = 0; i < 8; i++) begin
      data[8*i +: 8] = keep[i] ? byte_at(int'(beat_q) * 8 + i, seq_q) : 8'h00;
      keep_cnt       = keep_cnt + 4'(keep[i]);
    end
  end

  assign valid          = (state_q == SEND);
  assign hs             = valid & tx_axis_tready;
  assign tx_axis_tvalid = valid;
  assign tx_axis_tdata  = valid ? data : 64'h0;
  assign tx_axis_tkeep  = valid ? keep : 8'h00;
  assign tx_axis_tlast  = valid & last_beat;
  assign tx_axis_tuser  = 1'b0;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign frames_sent    = frames_q;
  assign bytes_sent     = bytes_q;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    seq_d    = seq_q;
    ep_d     = ep_q;
    gap_d    = gap_q;
    frames_d = frames_q;
    bytes_d  = bytes_q;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        if (!en_s_q) begin
          done_d = 1'b0;
          seq_d  = '0;
          ep_d   = '0;
        end else if (!done_q) begin
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (hs) begin
          bytes_d = bytes_q + 48'(keep_cnt);
          if (last_beat) begin
            frames_d = frames_q + 32'd1;
            seq_d    = seq_q + 32'd1;
            ep_d     = ep_q + 32'd1;
            beat_d   = '0;
            if ((NUM_FRAMES != 0) && ((ep_q + 32'd1) == 32'(NUM_FRAMES))) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (IFG_CYCLES == 0) begin
              state_d = en_s_q ? SEND : IDLE;
            end else begin
              state_d = GAP;
              gap_d   = 32'(IFG_CYCLES - 1);
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      GAP: begin
        if (gap_q == 32'd0) begin
          state_d = en_s_q ? SEND : IDLE;
          beat_d  = '0;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gen_clk or negedge gen_resetn) begin
    if (!gen_resetn) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      en_s_q   <= 1'b0;
      beat_q   <= '0;
      seq_q    <= '0;
      ep_q     <= '0;
      gap_q    <= '0;
      frames_q <= '0;
      bytes_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= pktgen_enable;
      en_s_q   <= sync1_q;
      beat_q   <= beat_d;
      seq_q    <= seq_d;
      ep_q     <= ep_d;
      gap_q    <= gap_d;
      frames_q <= frames_d;
      bytes_q  <= bytes_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mac_qsfp_pktgen.sv
// Bench for mac_qsfp_pktgen: four differently parameterised instances, each checked every cycle
// against a frame-level model (header bytes + ramp payload, beat/frame counts, gap length).
module tb_mac_qsfp_pktgen;

  localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h0A35_0001_0203;
  localparam logic [15:0] ET  = 16'h88B5;

  function automatic int fb_of(input int g);  return (g == 1) ? 61 : 60; endfunction
  function automatic int nf_of(input int g);  return (g == 2) ? 0 : ((g == 3) ? 4 : 16); endfunction
  function automatic int ifg_of(input int g); return (g == 3) ? 0 : 4; endfunction

  logic        clk = 1'b0;
  logic        rstn [4];
  logic        en   [4];
  logic        rdy  [4];
  logic [63:0] tdata [4];
  logic [7:0]  tkeep [4];
  logic        tvalid[4];
  logic        tlast [4];
  logic        tuser [4];
  logic        busy  [4];
  logic        done  [4];
  logic [31:0] fsent [4];
  logic [47:0] bsent [4];

  int total = 0;
  int bad   = 0;

  // Reference model state, one slot per instance.
  logic [31:0] seq_m   [4];
  int          beat_m  [4];
  int          ep_m    [4];
  int          gapc    [4];
  bit          after_tl[4];
  logic [31:0] frames_m[4];
  logic [47:0] bytes_m [4];
  bit          stall_q [4];
  logic [63:0] pd [4];
  logic [7:0]  pk [4];
  logic        pl [4];

  logic [63:0] cap_a [8];
  logic [7:0]  cap_akeep7;
  logic [7:0]  cap_bkeep;
  logic [63:0] cap_c2;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mac_qsfp_pktgen #(
      .FRAME_BYTES(g == 1 ? 61 : 60),
      .NUM_FRAMES (g == 2 ? 0 : (g == 3 ? 4 : 16)),
      .IFG_CYCLES (g == 3 ? 0 : 4),
      .DST_MAC    (DST),
      .SRC_MAC    (SRC),
      .ETHERTYPE  (ET)
    ) u_dut (
      .gen_clk       (clk),
      .gen_resetn    (rstn[g]),
      .pktgen_enable (en[g]),
      .tx_axis_tdata (tdata[g]),
      .tx_axis_tkeep (tkeep[g]),
      .tx_axis_tvalid(tvalid[g]),
      .tx_axis_tready(rdy[g]),
      .tx_axis_tlast (tlast[g]),
      .tx_axis_tuser (tuser[g]),
      .busy          (busy[g]),
      .done          (done[g]),
      .frames_sent   (fsent[g]),
      .bytes_sent    (bsent[g])
    );
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n, input logic [31:0] seq);
    logic [143:0] hdr;
    hdr = {DST, SRC, ET, seq};
    if (n < 18) return hdr[143 - 8*n -: 8];
    return 8'((n - 18) % 256);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) rdy[g] = (g == 1) ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      int          nb, fb;
      logic [63:0] ed;
      logic [7:0]  ek;
      logic        el;
      if (rstn[g] !== 1'b1) begin
        chk($sformatf("reset_outs[%0d]", g),
            {tvalid[g], tlast[g], tuser[g], busy[g], done[g], |tdata[g], |tkeep[g], |fsent[g], |bsent[g]}, 0);
        seq_m[g] = 0; beat_m[g] = 0; ep_m[g] = 0; gapc[g] = 0; after_tl[g] = 0;
        frames_m[g] = 0; bytes_m[g] = 0; stall_q[g] = 0;
        continue;
      end
      chk($sformatf("frames_sent[%0d]", g), fsent[g], frames_m[g]);
      chk($sformatf("bytes_sent[%0d]", g), bsent[g], bytes_m[g]);
      if (stall_q[g])
        chk($sformatf("stall_hold[%0d]", g), {tvalid[g], tdata[g], tkeep[g], tlast[g]}, {1'b1, pd[g], pk[g], pl[g]});
      if (tvalid[g]) begin
        if (after_tl[g]) begin
          chk($sformatf("ifg[%0d]", g), gapc[g], ifg_of(g));
          after_tl[g] = 0;
        end
        fb = fb_of(g);
        nb = fb - 8 * beat_m[g];
        if (nb > 8) nb = 8;
        ed = '0; ek = '0;
        for (int i = 0; i < nb; i++) begin
          ed[8*i +: 8] = exp_byte(8 * beat_m[g] + i, seq_m[g]);
          ek[i] = 1'b1;
        end
        el = (beat_m[g] == (fb + 7) / 8 - 1);
        chk($sformatf("tdata[%0d]", g), tdata[g], ed);
        chk($sformatf("tkeep_tlast_tuser[%0d]", g), {tkeep[g], tlast[g], tuser[g]}, {ek, el, 1'b0});
        if (rdy[g]) begin
          if (g == 0 && seq_m[0] == 0) cap_a[beat_m[0]] = tdata[0];
          if (g == 0 && beat_m[0] == 7) cap_akeep7 = tkeep[0];
          if (g == 1 && tlast[1]) cap_bkeep = tkeep[1];
          if (g == 2 && beat_m[2] == 2) cap_c2 = tdata[2];
          bytes_m[g] = bytes_m[g] + 48'(nb);
          if (el) begin
            frames_m[g]++;
            seq_m[g]++;
            ep_m[g]++;
            beat_m[g] = 0;
            if (!(nf_of(g) != 0 && ep_m[g] == nf_of(g))) begin
              after_tl[g] = 1;
              gapc[g] = 0;
            end
          end else begin
            beat_m[g]++;
          end
        end
      end else if (after_tl[g]) begin
        gapc[g]++;
      end
      stall_q[g] = tvalid[g] & ~rdy[g];
      pd[g] = tdata[g]; pk[g] = tkeep[g]; pl[g] = tlast[g];
    end
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int run, vcnt, i;
    for (int g = 0; g < 4; g++) begin
      rstn[g] = 1'b0; en[g] = 1'b0; rdy[g] = 1'b1;
    end
    repeat (5) @(negedge clk);
    for (int g = 0; g < 4; g++) rstn[g] = 1'b1;
    repeat (100) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("idle_valid[%0d]", g), tvalid[g], 0);
      chk($sformatf("idle_busy_done[%0d]", g), {busy[g], done[g]}, 0);
      chk($sformatf("idle_counters[%0d]", g), {fsent[g], bsent[g]}, 0);
    end

    // Default config: latency, header pins, 16-frame episode.
    @(negedge clk); en[0] = 1'b1;
    @(posedge clk); #1 chk("latency_edge1", tvalid[0], 0);
    @(posedge clk); #1 chk("latency_edge2", tvalid[0], 0);
    @(posedge clk); #1 chk("latency_edge3", tvalid[0], 1);
    for (i = 0; i < 1000 && done[0] !== 1'b1; i++) @(negedge clk);
    chk("a_done", done[0], 1);
    chk("a_frames", fsent[0], 16);
    chk("a_bytes", bsent[0], 960);
    chk("a_busy_after_done", busy[0], 0);
    chk("a_beat0", cap_a[0], 64'h350A_FFFF_FFFF_FFFF);
    chk("a_beat1", cap_a[1], 64'h0000_B588_0302_0100);
    chk("a_beat7_keep", cap_akeep7, 8'h0F);
    repeat (10) @(negedge clk);
    chk("a_done_sticky", {done[0], tvalid[0]}, 2'b10);
    en[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("a_done_cleared", done[0], 0);
    seq_m[0] = 0; ep_m[0] = 0; after_tl[0] = 0;

    // 61-byte frames under random backpressure.
    en[1] = 1'b1;
    for (i = 0; i < 4000 && done[1] !== 1'b1; i++) @(negedge clk);
    chk("b_done", done[1], 1);
    chk("b_frames", fsent[1], 16);
    chk("b_bytes", bsent[1], 976);
    chk("b_last_keep", cap_bkeep, 8'h1F);
    en[1] = 1'b0;

    // Free-running, enable dropped inside frame 2.
    en[2] = 1'b1;
    for (i = 0; i < 500 && !(seq_m[2] == 2 && beat_m[2] == 3 && tvalid[2] === 1'b1); i++) @(negedge clk);
    chk("c_reached_f2b3", seq_m[2], 2);
    en[2] = 1'b0;
    for (i = 0; i < 200 && fsent[2] != 3; i++) @(negedge clk);
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (tvalid[2] !== 1'b0) vcnt++;
      @(negedge clk);
    end
    chk("c_no_valid_after_drop", vcnt, 0);
    chk("c_frames", fsent[2], 3);
    seq_m[2] = 0; after_tl[2] = 0;
    en[2] = 1'b1;
    for (i = 0; i < 200 && fsent[2] != 4; i++) @(negedge clk);
    chk("c_restart_frames", fsent[2], 4);
    chk("c_restart_seq_beat2", cap_c2, 64'h0504_0302_0100_0000);
    en[2] = 1'b0;

    // Zero gap: four frames as one unbroken valid run.
    en[3] = 1'b1;
    for (i = 0; i < 20 && tvalid[3] !== 1'b1; i++) @(negedge clk);
    run = 0;
    while (tvalid[3] === 1'b1 && run < 100) begin
      run++;
      @(negedge clk);
    end
    chk("d_valid_run", run, 32);
    chk("d_done", done[3], 1);
    chk("d_frames", fsent[3], 4);
    en[3] = 1'b0;

    // Reset in the middle of a frame, enable held through it.
    repeat (5) @(negedge clk);
    en[0] = 1'b1;
    for (i = 0; i < 100 && !(tvalid[0] === 1'b1 && beat_m[0] == 3); i++) @(negedge clk);
    @(posedge clk); #2;
    chk("r_pre_valid", tvalid[0], 1);
    rstn[0] = 1'b0;
    #1;
    chk("r_async_valid", {tvalid[0], tlast[0], busy[0], done[0]}, 0);
    chk("r_async_data", {tdata[0], tkeep[0]}, 0);
    chk("r_async_counters", {fsent[0], bsent[0]}, 0);
    repeat (3) @(negedge clk);
    rstn[0] = 1'b1;
    for (i = 0; i < 100 && fsent[0] != 1; i++) @(negedge clk);
    chk("r_fresh_frame", fsent[0], 1);
    chk("r_fresh_beat2", cap_a[2], 64'h0504_0302_0100_0000);
    en[0] = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
